// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Brief    : VGA raster timing with a pixel-request stage and a registered
//            output stage; VGA_TEST_PATTERN_EN compiles in colour bars.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 2,
  parameter int CW       = 8
) (
  input  logic            CLOCK_50,
  input  logic            RESET_N,
  input  logic [3*CW-1:0] RGB_IN,
  input  logic            PATTERN_SEL,
  output logic            PIX_REQ,
  output logic [10:0]     PIX_X,
  output logic [9:0]      PIX_Y,
  output logic            FRAME_START,
  output logic            VGA_CLK,
  output logic            VGA_HS,
  output logic            VGA_VS,
  output logic            VGA_BLANK_N,
  output logic [CW-1:0]   VGA_R,
  output logic [CW-1:0]   VGA_G,
  output logic [CW-1:0]   VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] C_DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [10:0]      C_H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0]      C_H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0]      C_HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]      C_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]       C_V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       C_V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]       C_VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]       C_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic             C_HS_ON    = 1'(HS_POL);
  localparam logic             C_VS_ON    = 1'(VS_POL);

  logic [DIV_W-1:0] div_q, div_d;
  logic [10:0]      h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             vga_clk_q, vga_clk_d;
  logic             pix_ce, act, hs_act, vs_act;
  logic [3*CW-1:0]  rgb_sel;

  // Request stage
  logic             req_q, req_hs_q, req_vs_q, frame_start_q;
  logic [10:0]      pix_x_q;
  logic [9:0]       pix_y_q;

  // Output stage, one pixel period behind the request stage
  logic             blank_n_q, vga_hs_q, vga_vs_q;
  logic [3*CW-1:0]  rgb_q;

  always_comb begin
    pix_ce    = (div_q == C_DIV_LAST);
    div_d     = pix_ce ? '0 : div_q + 1'b1;
    vga_clk_d = (div_d < C_DIV_HALF);
    h_d       = h_q;
    v_d       = v_q;
    if (pix_ce) begin
      if (h_q == C_H_LAST) begin
        h_d = '0;
        v_d = (v_q == C_V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    act    = (h_q < C_H_ACT) && (v_q < C_V_ACT);
    hs_act = (h_q >= C_HS_BEG) && (h_q <= C_HS_END);
    vs_act = (v_q >= C_VS_BEG) && (v_q <= C_VS_END);
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [10:0] C_BAR_W = 11'(H_ACTIVE / 8);
  logic [2:0] bar_idx;

  // Bars follow the column of the request whose data is being captured.
  always_comb begin
    bar_idx = 3'(pix_x_q / C_BAR_W);
    rgb_sel = RGB_IN;
    if (PATTERN_SEL) begin
      rgb_sel = {{CW{bar_idx[2]}}, {CW{bar_idx[1]}}, {CW{bar_idx[0]}}};
    end
  end
`else
  logic pattern_sel_unused;
  assign pattern_sel_unused = PATTERN_SEL;
  assign rgb_sel            = RGB_IN;
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      vga_clk_q     <= 1'b0;
      req_q         <= 1'b0;
      req_hs_q      <= 1'b0;
      req_vs_q      <= 1'b0;
      frame_start_q <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      blank_n_q     <= 1'b0;
      vga_hs_q      <= ~C_HS_ON;
      vga_vs_q      <= ~C_VS_ON;
      rgb_q         <= '0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      vga_clk_q     <= vga_clk_d;
      frame_start_q <= 1'b0;
      if (pix_ce) begin
        req_q         <= act;
        req_hs_q      <= hs_act;
        req_vs_q      <= vs_act;
        pix_x_q       <= act ? h_q : '0;
        pix_y_q       <= act ? v_q : '0;
        frame_start_q <= (h_q == '0) && (v_q == '0);
        blank_n_q     <= req_q;
        vga_hs_q      <= req_hs_q ? C_HS_ON : ~C_HS_ON;
        vga_vs_q      <= req_vs_q ? C_VS_ON : ~C_VS_ON;
        rgb_q         <= req_q ? rgb_sel : '0;
      end
    end
  end

  assign PIX_REQ     = req_q;
  assign PIX_X       = pix_x_q;
  assign PIX_Y       = pix_y_q;
  assign FRAME_START = frame_start_q;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = vga_hs_q;
  assign VGA_VS      = vga_vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_R       = rgb_q[3*CW-1:2*CW];
  assign VGA_G       = rgb_q[2*CW-1:CW];
  assign VGA_B       = rgb_q[CW-1:0];

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- HS_POL / VS_POL, 0 / 0, sync active level
- CLK_DIV, 2, system clocks per pixel (even, >=2)
- CW, 8, bits per colour channel
REQ-002 SHALL have ports, one per line: name, direction, width, meaning. Clock and reset come first.
- CLOCK_50, in, 1, sole clock
- RESET_N, in, 1, asynchronous active-low reset
- RGB_IN, in, 3*CW, {R,G,B} pixel returned for the previous request
- PATTERN_SEL, in, 1, selects the internal test pattern (see REQ-019)
- PIX_REQ, out, 1, pixel data requested for PIX_X/PIX_Y
- PIX_X, out, 11, request column
- PIX_Y, out, 10, request row
- FRAME_START, out, 1, one-clock pulse at the first request of a frame
- VGA_CLK, out, 1, pixel clock
- VGA_HS, out, 1, horizontal sync
- VGA_VS, out, 1, vertical sync
- VGA_BLANK_N, out, 1, high during the visible area
- VGA_R / VGA_G / VGA_B, out, CW each, colour outputs

Function
REQ-003 SHALL run a divider counter 0..CLK_DIV-1 and assert internal pix_ce on the clock where the count wraps to 0.
REQ-004 SHALL drive VGA_CLK high while count < CLK_DIV/2. VGA_CLK therefore rises on the same clock edge at which pix_ce takes effect.
REQ-005 SHALL advance the horizontal counter h on each pix_ce over 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-006 SHALL advance the vertical counter v over 0..V_TOTAL-1 when h wraps, and SHALL wrap v to 0 after V_TOTAL-1.
REQ-007 SHALL hold PIX_REQ high while h < H_ACTIVE and v < V_ACTIVE, with PIX_X = h and PIX_Y = v. When PIX_REQ is low, PIX_X and PIX_Y SHALL be 0.
REQ-008 SHALL pulse FRAME_START for exactly one CLOCK_50 cycle on the pix_ce at which h = 0 and v = 0.
REQ-009 SHALL capture RGB_IN on the pix_ce that follows a request, and SHALL present it on VGA_R/G/B together with the matching sync and blank signals. The output stage is one pixel period later than the request stage.
REQ-010 SHALL assert HS during h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], at level HS_POL, delayed per REQ-009.
REQ-011 SHALL assert VS during v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], at level VS_POL, delayed per REQ-009.
REQ-012 SHALL force VGA_R/G/B to 0 whenever VGA_BLANK_N is low, regardless of RGB_IN.
REQ-013 SHALL register all outputs so that they change only on the edge where VGA_CLK rises. Outputs are then stable at the falling edge of VGA_CLK.
REQ-014 SHALL ignore RGB_IN on cycles without pix_ce.

Reset
REQ-015 SHALL, while RESET_N is low, clear the divider, h and v to 0, drive PIX_REQ, FRAME_START, VGA_CLK and VGA_BLANK_N to 0, drive VGA_R/G/B to 0, and hold VGA_HS = !HS_POL and VGA_VS = !VS_POL.
REQ-016 SHALL, on reset assertion mid-frame, drop all outputs to their reset values immediately (asynchronously) and discard any pending pixel.
REQ-017 SHALL, on the first pix_ce after RESET_N is released, start at h = 0, v = 0 and pulse FRAME_START.

Configuration
REQ-018 SHALL provide the macro VGA_TEST_PATTERN_EN to compile the internal test pattern in or out.
REQ-019 SHALL, with VGA_TEST_PATTERN_EN defined and PATTERN_SEL = 1, replace RGB_IN with 8 vertical colour bars, each H_ACTIVE/8 wide.
- Bar index i = PIX_X / (H_ACTIVE/8).
- R = {CW{i[2]}}, G = {CW{i[1]}}, B = {CW{i[0]}}.
REQ-020 SHALL, with VGA_TEST_PATTERN_EN undefined, ignore PATTERN_SEL and always use RGB_IN.

Verification
REQ-021 SHALL cover these directed scenarios (default parameters unless stated):
- Frame period: FRAME_START pulses are exactly 800*525*2 = 840000 clocks apart, and there are 307200 PIX_REQ pixel periods per frame.
- Horizontal sync: VGA_HS is low for 96 pixel periods per line and goes low 656 pixel periods after VGA_BLANK_N rises, on the output-stage timeline.
- Vertical sync: VGA_VS is low for 2 lines, starting 490 lines after the first visible line.
- Data path: RGB_IN = {x[7:0], y[7:0], 8'hA5} fed back from PIX_X/PIX_Y; pixel (100, 200) appears at the VGA_CLK negedge one period after its request as R = 100, G = 200, B = 8'hA5; VGA_R/G/B are 0 while blanked.
- Reset mid-line: RESET_N low at h = 300, v = 10; all outputs are at reset values within the same clock; after release, FRAME_START fires on the first pix_ce.
- Test pattern (VGA_TEST_PATTERN_EN defined, PATTERN_SEL = 1): column 0 gives 000000, column 80 gives 0000FF, column 639 gives FFFFFF.
